// File: rtl/sram_ctrl_gen.sv
// sram_ctrl_gen: parametrised controller for one external asynchronous SRAM.
// A valid/ready request port drives registered, glitch-free SRAM strobes with
// configurable read/write wait states, per-byte write enables, a one-cycle
// read-response pulse and a one-cycle write-done pulse.
// Optional build macro SRAM_CTRL_BURST_EN adds req_len for multi-beat reads.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request, all strobes inactive, dq released
// RD      | ce_n/oe_n low for RD_WAIT cycles, sample dq on the last edge
// RD_DONE | rsp_valid pulse, strobes back high
// WR      | ce_n/we_n low for WR_WAIT cycles, dq driven
// WR_HOLD | we_n high, ce_n low, dq still driven for hold time; wr_done

module sram_ctrl_gen #(
  parameter int AW      = 18,
  parameter int DW      = 16,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  localparam int BW     = DW / 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_rw,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [BW-1:0] req_be,
`ifdef SRAM_CTRL_BURST_EN
  input  logic [3:0]    req_len,
`endif
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          wr_done,
  output logic [AW-1:0] sram_addr,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic [BW-1:0] sram_be_n,
  inout  logic [DW-1:0] sram_dq
);

  localparam int WMAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW   = (WMAX > 1) ? $clog2(WMAX) : 1;
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_WAIT - 1);

  // Reject parameter sets that cannot produce a legal strobe sequence.
  if (RD_WAIT < 1 || WR_WAIT < 1 || DW < 8 || (DW % 8) != 0) begin : g_param_check
    $error("sram_ctrl_gen: RD_WAIT/WR_WAIT must be >= 1 and DW a multiple of 8");
  end

  typedef enum logic [2:0] {IDLE, RD, RD_DONE, WR, WR_HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dq_out;
  logic          dq_oe;
`ifdef SRAM_CTRL_BURST_EN
  logic [3:0]    beats_left;
`endif

  // Only a register enables the bus driver, so dq never glitches onto the pins.
  assign sram_dq = dq_oe ? dq_out : 'z;

  // Sequencer: state, wait counter and every registered output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      wr_done    <= 1'b0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= '1;
      dq_out     <= '0;
      dq_oe      <= 1'b0;
`ifdef SRAM_CTRL_BURST_EN
      beats_left <= 4'd0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      wr_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            sram_addr <= req_addr;
            sram_ce_n <= 1'b0;
            if (req_rw) begin
              state     <= RD;
              cnt       <= RD_LOAD;
              sram_oe_n <= 1'b0;
              sram_be_n <= '0;
`ifdef SRAM_CTRL_BURST_EN
              beats_left <= req_len;
`endif
            end else begin
              state     <= WR;
              cnt       <= WR_LOAD;
              sram_we_n <= 1'b0;
              sram_be_n <= ~req_be;
              dq_out    <= req_wdata;
              dq_oe     <= 1'b1;
            end
          end
        end
        RD: begin
          if (cnt == '0) begin
            rsp_rdata <= sram_dq;
            rsp_valid <= 1'b1;
`ifdef SRAM_CTRL_BURST_EN
            // Further beats keep oe_n low and just advance the address.
            if (beats_left != 4'd0) begin
              beats_left <= beats_left - 4'd1;
              sram_addr  <= sram_addr + AW'(1);
              cnt        <= RD_LOAD;
            end else begin
              state     <= RD_DONE;
              sram_ce_n <= 1'b1;
              sram_oe_n <= 1'b1;
              sram_be_n <= '1;
            end
`else
            state     <= RD_DONE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= '1;
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RD_DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        WR: begin
          if (cnt == '0) begin
            state     <= WR_HOLD;
            sram_we_n <= 1'b1;
            wr_done   <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WR_HOLD: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          sram_ce_n <= 1'b1;
          sram_be_n <= '1;
          dq_oe     <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          sram_be_n <= '1;
          dq_oe     <= 1'b0;
        end
      endcase
    end
  end

endmodule
